prefetch_buffer: RTL and testbench

PREFETCH_BUFFER -- requirements
Module: prefetch_buffer

---
 rtl/prefetch_buffer.sv | 200 ++++++++++++++++++++
 tb/tb_prefetch_buffer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : prefetch_buffer
//  Purpose  : Instruction prefetch queue. Issues pipelined word reads to the
//             memory controller (response arrives one cycle after request),
//             buffers DEPTH tagged entries and presents the oldest one to
//             decode. A branch/flush from execute discards everything and
//             restarts fetch at the new address.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH       number of buffered entries (power of two, >= 2)
//  Ports
//    clk         clock, all state on rising edge
//    n_reset     asynchronous active-low reset
//    write_pc_i  flush request; restarts fetch at pc_i
//    pc_i        new fetch word address
//    addr        word address to memory controller
//    trans       transfer type: 00 IDLE, 10 NSEQ, 11 SEQ
//    rdata       read data, valid the cycle after a request
//    abort       memory abort, qualifies rdata
//    ready_i     decode accepts head entry
//    valid_o     head entry present
//    instr_o     head instruction word
//    pc_o        word address of head instruction
//    abort_o     head entry aborted
//    count_o     number of entries held
//  Build option
//    PREFETCH_ABORT_EN  when defined, abort is stored per entry and shown on
//                       abort_o; otherwise abort is ignored and abort_o = 0.
// ============================================================================
module prefetch_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     n_reset,
   input  logic                     write_pc_i,
   input  logic [31:0]              pc_i,
   output logic [31:0]              addr,
   output logic [1:0]               trans,
   input  logic [31:0]              rdata,
   input  logic                     abort,
   input  logic                     ready_i,
   output logic                     valid_o,
   output logic [31:0]              instr_o,
   output logic [31:0]              pc_o,
   output logic                     abort_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W:0] c_DEPTH_EXT = (c_CNT_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_FETCH = 2'b00,
      S_FULL  = 2'b01,
      S_FLUSH = 2'b10
   } state_t;

   state_t               r_state;
   state_t               w_state_next;

   logic                 r_en;          // low until the first edge after reset
   logic [31:0]          r_addr;
   logic                 r_pend;        // a request was issued last cycle
   logic [31:0]          r_pend_addr;   // tag of that request
   logic [c_PTR_W-1:0]   r_wptr;
   logic [c_PTR_W-1:0]   r_rptr;
   logic [c_CNT_W-1:0]   r_count;

   logic [31:0]          r_instr_mem [DEPTH];
   logic [31:0]          r_pc_mem    [DEPTH];

   logic                 w_issue;
   logic                 w_pend_next;
   logic                 w_push;
   logic                 w_pop;
   logic [c_CNT_W-1:0]   w_count_next;
   logic [c_CNT_W:0]     w_sum_next;

   // A flush outranks both the response capture and the decode pop.
   assign w_push       = r_pend && !write_pc_i;
   assign w_pop        = valid_o && ready_i && !write_pc_i;
   assign w_count_next = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state and bus outputs
   // The gating decision for the next cycle is made from next-cycle occupancy
   // (entries + in-flight request), so FULL always means "no room" and FETCH
   // always has room for one more response.
   // ------------------------------------------------------------------------
   always_comb begin
      w_issue      = 1'b0;
      trans        = 2'b00;
      w_pend_next  = 1'b0;
      w_sum_next   = '0;
      w_state_next = r_state;

      if (r_en && (r_state != S_FULL)) begin
         w_issue = 1'b1;
         // back-to-back requests are sequential; anything else starts anew
         trans   = r_pend ? 2'b11 : 2'b10;
      end

      w_pend_next = w_issue && !write_pc_i;
      w_sum_next  = {1'b0, w_count_next} + (c_CNT_W + 1)'(w_pend_next);

      if (write_pc_i) begin
         w_state_next = S_FLUSH;
      end else if (w_sum_next < c_DEPTH_EXT) begin
         w_state_next = S_FETCH;
      end else begin
         w_state_next = S_FULL;
      end
   end

   // ------------------------------------------------------------------------
   // Fetch address, in-flight tracking, pointers and occupancy
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_en        <= 1'b0;
         r_addr      <= '0;
         r_pend      <= 1'b0;
         r_pend_addr <= '0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
      end else begin
         r_en <= 1'b1;
         if (write_pc_i) begin
            // dropping r_pend discards the response of this cycle's request
            r_addr  <= pc_i;
            r_pend  <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
         end else begin
            if (w_issue) begin
               r_addr      <= r_addr + 32'd1;
               r_pend_addr <= r_addr;
            end
            r_pend <= w_issue;
            if (w_push) begin
               r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
               r_rptr <= r_rptr + c_PTR_W'(1);
            end
            r_count <= w_count_next;
         end
      end
   end

   // Entry storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_instr_mem[r_wptr] <= rdata;
         r_pc_mem[r_wptr]    <= r_pend_addr;
      end
   end

   assign addr    = r_addr;
   assign count_o = r_count;
   assign valid_o = (r_count != '0);
   // Head fields are forced to zero while empty so stale entries never leak.
   assign instr_o = valid_o ? r_instr_mem[r_rptr] : 32'd0;
   assign pc_o    = valid_o ? r_pc_mem[r_rptr]    : 32'd0;

`ifdef PREFETCH_ABORT_EN
   logic r_abort_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_abort_mem[r_wptr] <= abort;
      end
   end

   assign abort_o = valid_o ? r_abort_mem[r_rptr] : 1'b0;
`else
   logic w_unused_abort;

   assign w_unused_abort = abort;
   assign abort_o        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prefetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prefetch_buffer
//  Purpose  : Directed self-checking bench for prefetch_buffer (DEPTH = 4).
//             Memory model returns 0x100 + address one cycle after request;
//             abort can be armed for address 2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prefetch_buffer;

   localparam int DEPTH = 4;
`ifdef PREFETCH_ABORT_EN
   localparam bit c_ABORT_ON = 1'b1;
`else
   localparam bit c_ABORT_ON = 1'b0;
`endif

   logic        clk        = 1'b0;
   logic        n_reset    = 1'b0;
   logic        write_pc_i = 1'b0;
   logic [31:0] pc_i       = 32'd0;
   logic        ready_i    = 1'b0;
   logic        abort_arm  = 1'b0;
   logic [31:0] addr;
   logic [1:0]  trans;
   logic [31:0] rdata;
   logic        abort;
   logic        valid_o;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        abort_o;
   logic [2:0]  count_o;
   logic [31:0] r_req_addr;

   int n_cmp = 0;
   int n_err = 0;

   prefetch_buffer #(.DEPTH(DEPTH)) u_dut (
      .clk        (clk),
      .n_reset    (n_reset),
      .write_pc_i (write_pc_i),
      .pc_i       (pc_i),
      .addr       (addr),
      .trans      (trans),
      .rdata      (rdata),
      .abort      (abort),
      .ready_i    (ready_i),
      .valid_o    (valid_o),
      .instr_o    (instr_o),
      .pc_o       (pc_o),
      .abort_o    (abort_o),
      .count_o    (count_o)
   );

   always #5 clk = ~clk;

   // memory: latch the request address, answer during the following cycle
   always @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_req_addr <= 32'd0;
      end else if (trans != 2'b00) begin
         r_req_addr <= addr;
      end
   end
   assign rdata = 32'h100 + r_req_addr;
   assign abort = abort_arm && (r_req_addr == 32'd2);

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // asynchronous reset pulse between edges; outputs must clear at once
   task automatic do_reset(input string tag);
      n_reset = 1'b0;
      #1;
      check_val({tag, "_rst_addr"},  addr, 32'd0);
      check_val({tag, "_rst_trans"}, 32'(trans), 32'd0);
      check_val({tag, "_rst_valid"}, 32'(valid_o), 32'd0);
      check_val({tag, "_rst_count"}, 32'(count_o), 32'd0);
      check_val({tag, "_rst_instr"}, instr_o, 32'd0);
      check_val({tag, "_rst_pc"},    pc_o, 32'd0);
      check_val({tag, "_rst_abort"}, 32'(abort_o), 32'd0);
      #2;
      n_reset = 1'b1;
   endtask

   // reset with decode stalled and run until the buffer is full (S6)
   task automatic fill_from_reset(input string tag);
      ready_i = 1'b0;
      do_reset(tag);
      for (int i = 0; i < 6; i++) tick();
   endtask

   initial begin
      // ---------------- A: streaming from reset, abort on address 2
      tick();
      ready_i   = 1'b1;
      abort_arm = 1'b1;
      do_reset("A");
      tick();
      check_val("A_c1_addr",  addr, 32'd0);
      check_val("A_c1_trans", 32'(trans), 32'd2);
      tick();
      check_val("A_c2_addr",  addr, 32'd1);
      check_val("A_c2_trans", 32'(trans), 32'd3);
      check_val("A_c2_valid", 32'(valid_o), 32'd0);
      for (int k = 0; k < 6; k++) begin
         tick();
         check_val("A_valid", 32'(valid_o), 32'd1);
         check_val("A_pc",    pc_o, 32'(k));
         check_val("A_instr", instr_o, 32'h100 + 32'(k));
         check_val("A_abort", 32'(abort_o), 32'(c_ABORT_ON && (k == 2)));
      end
      abort_arm = 1'b0;

      // ---------------- B: stalled decode fills exactly DEPTH entries
      ready_i = 1'b0;
      do_reset("B");
      for (int k = 0; k < 4; k++) begin
         tick();
         check_val("B_req_addr", addr, 32'(k));
         check_val("B_req_trans", 32'(trans), (k == 0) ? 32'd2 : 32'd3);
      end
      tick();                                   // S5
      check_val("B_s5_trans", 32'(trans), 32'd0);
      check_val("B_s5_count", 32'(count_o), 32'd3);
      tick();                                   // S6
      check_val("B_s6_trans", 32'(trans), 32'd0);
      check_val("B_s6_count", 32'(count_o), 32'd4);
      check_val("B_s6_pc",    pc_o, 32'd0);
      tick();                                   // S7
      check_val("B_s7_trans", 32'(trans), 32'd0);
      ready_i = 1'b1;
      tick();                                   // S8: pc 0 popped
      ready_i = 1'b0;
      check_val("B_s8_pc",    pc_o, 32'd1);
      check_val("B_s8_count", 32'(count_o), 32'd3);
      check_val("B_s8_addr",  addr, 32'd4);
      check_val("B_s8_req",   32'(trans != 2'b00), 32'd1);
      tick();                                   // S9
      check_val("B_s9_trans", 32'(trans), 32'd0);
      tick();                                   // S10
      check_val("B_s10_count", 32'(count_o), 32'd4);
      check_val("B_s10_pc",    pc_o, 32'd1);

      // ---------------- C: flush with 3 held and 1 outstanding
      ready_i = 1'b0;
      do_reset("C");
      for (int i = 0; i < 5; i++) tick();       // S5
      check_val("C_s5_count", 32'(count_o), 32'd3);
      write_pc_i = 1'b1;
      pc_i       = 32'h40;
      tick();                                   // S6 = N+1
      write_pc_i = 1'b0;
      check_val("C_n1_valid", 32'(valid_o), 32'd0);
      check_val("C_n1_count", 32'(count_o), 32'd0);
      check_val("C_n1_addr",  addr, 32'h40);
      check_val("C_n1_trans", 32'(trans), 32'd2);
      tick();                                   // N+2
      check_val("C_n2_valid", 32'(valid_o), 32'd0);
      check_val("C_n2_trans", 32'(trans), 32'd3);
      tick();                                   // N+3
      check_val("C_n3_valid", 32'(valid_o), 32'd1);
      check_val("C_n3_pc",    pc_o, 32'h40);
      check_val("C_n3_instr", instr_o, 32'h140);
      ready_i = 1'b1;
      tick();
      check_val("C_next_pc", pc_o, 32'h41);
      tick();
      check_val("C_next2_pc", pc_o, 32'h42);

      // ---------------- D: flush beats pop on a full buffer, repeated flush
      fill_from_reset("D");
      check_val("D_full_count", 32'(count_o), 32'd4);
      write_pc_i = 1'b1;
      pc_i       = 32'h80;
      ready_i    = 1'b1;
      tick();
      check_val("D_f1_count", 32'(count_o), 32'd0);
      check_val("D_f1_valid", 32'(valid_o), 32'd0);
      check_val("D_f1_addr",  addr, 32'h80);
      check_val("D_f1_trans", 32'(trans), 32'd2);
      pc_i = 32'h90;
      tick();
      write_pc_i = 1'b0;
      check_val("D_f2_addr",  addr, 32'h90);
      check_val("D_f2_trans", 32'(trans), 32'd2);
      check_val("D_f2_count", 32'(count_o), 32'd0);
      tick();
      check_val("D_f3_addr",  addr, 32'h91);
      check_val("D_f3_valid", 32'(valid_o), 32'd0);
      tick();
      check_val("D_f4_valid", 32'(valid_o), 32'd1);
      check_val("D_f4_pc",    pc_o, 32'h90);
      check_val("D_f4_instr", instr_o, 32'h190);

      // ---------------- E: async reset pulse while full
      fill_from_reset("E0");
      check_val("E_full_count", 32'(count_o), 32'd4);
      do_reset("E");
      tick();
      check_val("E_c1_addr",  addr, 32'd0);
      check_val("E_c1_trans", 32'(trans), 32'd2);
      check_val("E_c1_valid", 32'(valid_o), 32'd0);
      tick();
      check_val("E_c2_valid", 32'(valid_o), 32'd0);
      tick();
      check_val("E_c3_valid", 32'(valid_o), 32'd1);
      check_val("E_c3_pc",    pc_o, 32'd0);
      check_val("E_c3_count", 32'(count_o), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
